// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction prefetch queue.
//   fq_entry_t   - {pc, instr} pair held by one queue slot (default widths)
//   FQ_*         - default geometry / reset constants for fetch_queue
//   FQ_NOP       - no-operation instruction encoding
package fetch_pkg;

   localparam int FQ_ADDR_W  = 16;
   localparam int FQ_INSTR_W = 32;
   localparam int FQ_DEPTH   = 4;
   localparam int FQ_PC_STEP = 4;

   localparam logic [FQ_ADDR_W-1:0]  FQ_RESET_PC = 16'h0000;
   localparam logic [FQ_INSTR_W-1:0] FQ_NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [FQ_ADDR_W-1:0]  pc;
      logic [FQ_INSTR_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry circular buffer of {pc, instr} pairs.
// Ports:
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   clear           - drop all entries (pointers to zero)
//   wr_en/wr_pc/wr_instr - write one entry at the write pointer
//   rd_en           - advance the read pointer past the head
//   rd_pc/rd_instr  - asynchronous read of the head entry
// Reset also zeroes the array so the head reads 0 right after reset.
module fq_storage
   import fetch_pkg::*;
#(
   parameter int DEPTH   = FQ_DEPTH,
   parameter int ADDR_W  = FQ_ADDR_W,
   parameter int INSTR_W = FQ_INSTR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_pc,
   input  logic [INSTR_W-1:0] wr_instr,
   input  logic               rd_en,
   output logic [ADDR_W-1:0]  rd_pc,
   output logic [INSTR_W-1:0] rd_instr
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;

   // Entry array and wrapping read/write pointers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]    <= '0;
            instr_mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (clear) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_en) begin
            pc_mem_r[wr_ptr_r]    <= wr_pc;
            instr_mem_r[wr_ptr_r] <= wr_instr;
            wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   assign rd_pc    = pc_mem_r[rd_ptr_r];
   assign rd_instr = instr_mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage. Owns the fetch PC, reads the
// combinational ROM whenever there is room, and queues {pc, instr} pairs
// for the control unit (valid/ready). A redirect flushes and restarts.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   fetch_en                  - allow ROM reads (pops still allowed when low)
//   redirect, redirect_pc     - flush and restart fetching at redirect_pc
//   rom_addr / rom_data       - ROM address (= fetch PC) and its data
//   instr_valid/instr_ready   - head handshake
//   instr, instr_pc           - head instruction and its PC
//   count                     - occupied entries
// Build option: FETCH_QUEUE_BYPASS_EN forwards rom_data straight to the
// outputs when the queue is empty, removing one cycle of latency.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                DEPTH    = FQ_DEPTH,
   parameter int                ADDR_W   = FQ_ADDR_W,
   parameter int                INSTR_W  = FQ_INSTR_W,
   parameter int                PC_STEP  = FQ_PC_STEP,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     fetch_en,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [INSTR_W-1:0]       rom_data,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [INSTR_W-1:0]       instr,
   output logic [ADDR_W-1:0]        instr_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0]  fetch_pc_r;
   logic [CNT_W-1:0]   count_r;
   logic               q_valid_s;
   logic               space_s;
   logic               push_s;
   logic               pop_s;
   logic               byp_s;
   logic               wr_en_s;
   logic               rd_en_s;
   logic [ADDR_W-1:0]  q_pc_s;
   logic [INSTR_W-1:0] q_instr_s;

   // Push/pop decode and head mux. Room is computed from the stored head
   // only, so push never depends on the bypassed valid (no comb loop).
   always_comb begin
      q_valid_s = (count_r != {CNT_W{1'b0}});
      space_s   = (count_r < DEPTH_C) | (q_valid_s & instr_ready);
      push_s    = fetch_en & ~redirect & ~reset & space_s;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp_s     = ~q_valid_s & push_s;
`else
      byp_s     = 1'b0;
`endif
      if (byp_s) begin
         instr_valid = 1'b1;
         instr       = rom_data;
         instr_pc    = fetch_pc_r;
      end else begin
         instr_valid = q_valid_s;
         instr       = q_instr_s;
         instr_pc    = q_pc_s;
      end
      pop_s   = instr_valid & instr_ready;
      // A bypassed entry that is consumed immediately is never stored.
      wr_en_s = push_s & ~(byp_s & pop_s);
      rd_en_s = pop_s & ~byp_s & ~redirect;
   end

   // Fetch PC and occupancy; redirect overrides push and pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_r <= RESET_PC;
         count_r    <= '0;
      end else if (redirect) begin
         fetch_pc_r <= redirect_pc;
         count_r    <= '0;
      end else begin
         if (push_s) begin
            fetch_pc_r <= fetch_pc_r + STEP_C;
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   fq_storage #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_storage (
      .clock    (clock),
      .reset    (reset),
      .clear    (redirect),
      .wr_en    (wr_en_s),
      .wr_pc    (fetch_pc_r),
      .wr_instr (rom_data),
      .rd_en    (rd_en_s),
      .rd_pc    (q_pc_s),
      .rd_instr (q_instr_s)
   );

   assign rom_addr = fetch_pc_r;
   assign count    = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. Stimulus pushes the
// expected {pc, instr} stream; negedge monitors pop and compare on every
// handshake. A second instance with RESET_PC = 16'hFFF8 covers PC wrap.
module tb_fetch_queue;
   import fetch_pkg::*;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, fetch_en, redirect, instr_ready;
   logic [15:0] redirect_pc, rom_addr, instr_pc;
   logic [31:0] rom_data, instr;
   logic        instr_valid;
   logic [2:0]  count;

   logic        reset2, fetch_en2;
   logic [15:0] rom_addr2, instr_pc2;
   logic [31:0] rom_data2, instr2;
   logic        instr_valid2;
   logic [2:0]  count2;

   fq_entry_t exp_q[$];
   fq_entry_t exp2_q[$];
   int checks = 0;
   int errors = 0;
   int pops2  = 0;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   function automatic logic [31:0] rom_f(input logic [15:0] a);
      return {a ^ 16'h5A5A, a};
   endfunction

   assign rom_data  = rom_f(rom_addr);
   assign rom_data2 = rom_f(rom_addr2);

   fetch_queue #(.DEPTH(4), .ADDR_W(16), .INSTR_W(32), .PC_STEP(4),
                 .RESET_PC(16'h0000)) dut (
      .clock(clock), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .count(count));

   fetch_queue #(.DEPTH(4), .ADDR_W(16), .INSTR_W(32), .PC_STEP(4),
                 .RESET_PC(16'hFFF8)) dut_wrap (
      .clock(clock), .reset(reset2), .fetch_en(fetch_en2), .redirect(1'b0),
      .redirect_pc(16'h0000), .rom_addr(rom_addr2), .rom_data(rom_data2),
      .instr_valid(instr_valid2), .instr_ready(1'b1), .instr(instr2),
      .instr_pc(instr_pc2), .count(count2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_stream(input logic [15:0] start, input int n);
      fq_entry_t e;
      for (int i = 0; i < n; i++) begin
         e.pc    = start + 16'(4 * i);
         e.instr = rom_f(e.pc);
         exp_q.push_back(e);
      end
   endtask

   // Main scoreboard monitor.
   always @(negedge clock) begin
      fq_entry_t e;
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected actual_pc=%h expected=none", instr_pc);
         end else begin
            e = exp_q.pop_front();
            chk("mon_pc", {16'h0000, instr_pc}, {16'h0000, e.pc});
            chk("mon_instr", instr, e.instr);
         end
      end
   end

   // Wrap-instance monitor (its consumer is always ready).
   always @(negedge clock) begin
      fq_entry_t e;
      if (instr_valid2 === 1'b1) begin
         if (exp2_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wrap_unexpected actual_pc=%h expected=none", instr_pc2);
         end else begin
            e = exp2_q.pop_front();
            pops2++;
            chk("wrap_pc", {16'h0000, instr_pc2}, {16'h0000, e.pc});
            chk("wrap_instr", instr2, e.instr);
         end
      end
   end

   initial begin
      fq_entry_t e;
      int got2;
      reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
      redirect_pc = 16'h0000; reset2 = 1'b1; fetch_en2 = 1'b0;
      tick(); tick();
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_rom_addr", {16'h0000, rom_addr}, 32'h0000_0000);
      chk("rst_instr", instr, 32'h0000_0000);

      // Fill with the consumer stalled.
      reset = 1'b0; fetch_en = 1'b1;
      expect_stream(16'h0000, 24);
      #1;
      chk("first_valid", {31'd0, instr_valid}, {31'd0, BYP});
      if (BYP) chk("first_byp_instr", instr, rom_f(16'h0000));
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("fill_rom_addr", {16'h0000, rom_addr}, (k < 4) ? 32'(4 * k) : 32'd16);
         chk("fill_count", {29'd0, count}, (k < 4) ? 32'(k) : 32'd4);
         chk("fill_valid", {31'd0, instr_valid}, 32'd1);
      end
      chk("full_instr_pc", {16'h0000, instr_pc}, 32'h0000_0000);
      chk("full_instr", instr, rom_f(16'h0000));

      // Streaming from full: count holds, no bubbles.
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("stream_count", {29'd0, count}, 32'd4);
         chk("stream_valid", {31'd0, instr_valid}, 32'd1);
      end

      // One pop without push brings count to 3, then redirect.
      fetch_en = 1'b0;
      tick();
      chk("pre_redir_count", {29'd0, count}, 32'd3);
      fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
      tick();
      redirect = 1'b0; fetch_en = 1'b0;
      #1;
      chk("redir_count", {29'd0, count}, 32'd0);
      chk("redir_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_rom_addr", {16'h0000, rom_addr}, 32'h0000_0040);
      exp_q.delete();
      expect_stream(16'h0040, 16);
      fetch_en = 1'b1;
      for (int k = 0; k < 5; k++) tick();

      // Build count = 2 then reset mid-stream.
      instr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (count == 3'd2) break;
         tick();
      end
      chk("pre_rst_count", {29'd0, count}, 32'd2);
      reset = 1'b1;
      tick();
      chk("mid_rst_count", {29'd0, count}, 32'd0);
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_rom_addr", {16'h0000, rom_addr}, 32'h0000_0000);
      chk("mid_rst_instr", instr, 32'h0000_0000);
      chk("mid_rst_instr_pc", {16'h0000, instr_pc}, 32'h0000_0000);
      reset = 1'b0; fetch_en = 1'b0;
      exp_q.delete();
      expect_stream(16'h0000, 16);
      fetch_en = 1'b1; instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      chk("flow_count", {29'd0, count}, BYP ? 32'd0 : 32'd1);
      fetch_en = 1'b0;
      tick(); tick();

      // PC wrap on the second instance.
      for (int i = 0; i < 10; i++) begin
         e.pc    = 16'hFFF8 + 16'(4 * i);
         e.instr = rom_f(e.pc);
         exp2_q.push_back(e);
      end
      reset2 = 1'b0; fetch_en2 = 1'b1;
      #1;
      chk("wrap_rom_addr", {16'h0000, rom_addr2}, 32'h0000_FFF8);
      for (int k = 0; k < 6; k++) tick();
      fetch_en2 = 1'b0;
      got2 = pops2;
      chk("wrap_pops", {31'd0, got2 >= 4}, 32'd1);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage sitting directly upstream of the instruction register. It owns the fetch address, reads the combinational instruction ROM every cycle it has space, and buffers {pc, instruction} pairs in a small circular queue. The control unit pops instructions with a valid/ready handshake. Taken branches and jumps flush the queue through a redirect port.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- ADDR_W, 16: PC and ROM address width.
- INSTR_W, 32: instruction width.
- PC_STEP, 4: byte increment between sequential fetches.
- RESET_PC, 0: fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- fetch_en  in  1  allows ROM reads; 0 stalls fetching (pops still allowed).
- redirect  in  1  flush the queue and restart fetching at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- rom_addr  out  ADDR_W  address to ROM; always equals fetch_pc.
- rom_data  in  INSTR_W  combinational ROM data for rom_addr.
- instr_valid  out  1  head entry present.
- instr_ready  in  1  consumer accepts the head this cycle.
- instr  out  INSTR_W  head instruction.
- instr_pc  out  ADDR_W  PC of the head instruction.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- push = fetch_en & ~redirect & (count < DEPTH | pop).
- On push: write {fetch_pc, rom_data} at the write pointer, then set fetch_pc <= fetch_pc + PC_STEP.
- pop = instr_valid & instr_ready. A pop advances the read pointer.
- Push and pop in the same cycle leave count unchanged. This applies when full and when it is empty only with bypass (see Configuration).
- Redirect has priority over everything:
  - Pointers and count clear; the pop is discarded.
  - fetch_pc <= redirect_pc; no push that cycle.
- fetch_pc is modulo 2^ADDR_W: 16'hFFFC + 4 wraps to 16'h0000.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Full (count == DEPTH) with no pop: no push; rom_addr holds.
- Empty: instr_valid = 0; instr and instr_pc hold their last value (don't-care).
- Reset, including mid-stream:
  - count = 0, pointers = 0, fetch_pc = RESET_PC.
  - instr_valid = 0; instr = 0; instr_pc = 0.
  - rom_addr = RESET_PC.

## Timing
- rom_addr is registered (fetch_pc), so ROM data is sampled in the same cycle.
- Latency from first fetch to instr_valid: 1 cycle without bypass, 0 cycles with bypass.
- Redirect at edge N: rom_addr = redirect_pc in cycle N+1. The first new instruction is valid in N+2 (no bypass) or N+1 (bypass).
- Sustained throughput: 1 instruction/cycle when instr_ready is held high.
- instr, instr_pc and instr_valid depend only on registers, except in the bypass path.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count == 0 and push is active, instr_valid = 1, instr = rom_data and instr_pc = fetch_pc combinationally.
  - If popped that cycle, the entry is not written (count stays 0).
- Undefined: outputs come only from queue storage; the minimum fetch-to-issue latency is 1 cycle.

## Structure
- Package fetch_pkg holds:
  - typedef fq_entry_t {pc [ADDR_W], instr [INSTR_W]};
  - default constants FQ_DEPTH, FQ_PC_STEP, FQ_RESET_PC;
  - localparam NOP instruction encoding for bench use.
- One sub-module, fq_storage: a DEPTH x entry register array with write port and asynchronous read port, plus pointers.
- Control, the PC counter and the bypass mux live in fetch_queue.

## Test plan
- Reset, then fetch_en=1, instr_ready=0 for 6 cycles:
  - rom_addr steps 0, 4, 8, 12 then holds at 16.
  - count = 4.
  - instr_pc = 0 and instr = ROM[0].
- Queue full, then instr_ready=1 continuously:
  - one pop and one push per cycle; count stays 4;
  - instr_pc sequence is 0, 4, 8, …;
  - no gaps.
- Redirect to 16'h0040 while count=3 and instr_ready=1:
  - next cycle count=0, instr_valid=0, rom_addr=16'h0040;
  - the first following instruction has instr_pc=16'h0040.
- RESET_PC=16'hFFF8, free running:
  - instr_pc sequence is FFF8, FFFC, 0000, 0004.
- Assert reset mid-stream with count=2:
  - next cycle count=0, instr_valid=0, rom_addr=RESET_PC;
  - instr and instr_pc read 0.
- With FETCH_QUEUE_BYPASS_EN, after reset with instr_ready=1:
  - instr_valid=1 in the first fetch cycle, with instr = ROM[0];
  - count stays 0.
- Without the macro:
  - instr_valid first rises one cycle later.
